imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle core's instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes each word into instruction memory through a one-cycle write strobe. The core is held in reset until a complete frame with a correct checksum has been written.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the loader's byte-stream handshake and its instruction-memory
//   write bus.
//   Stream : in_valid, in_data (source -> loader), in_ready (loader -> source)
//   Memory : we, waddr, wdata (loader -> instruction memory)
//   modport master : the loader side
//   modport slave  : the environment side (byte source + instruction memory)
interface imem_loader_if #(
    parameter int AW = 4
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Receives a framed byte stream
//   (header N, 4*N big-endian data bytes, XOR checksum byte), writes each
//   assembled 32-bit word into instruction memory with a one-cycle strobe,
//   and releases the core from reset only after a frame with a correct
//   checksum has been fully written.
//   Ports:
//     clk       : clock, rising edge
//     rst       : asynchronous active-low reset
//     start     : single-cycle request to begin a new load
//     bus       : stream handshake + memory write bus (imem_loader_if.master)
//     busy      : frame in progress (HDR, DATA, CSUM)
//     done      : last frame loaded successfully
//     error     : last frame failed
//     cpu_rst_n : active-low core reset, high only in DONE
module imem_loader #(
    parameter int WORDS = 16,
    parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0] MAX_N = 9'(WORDS);

    state_t        state;
    logic [7:0]    n_words;
    logic [7:0]    word_idx;
    logic [7:0]    acc;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [31:0]   wdata_q;
    logic          rdy;
    logic          accept;

    assign rdy          = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign accept       = bus.in_valid && rdy;
    assign bus.in_ready = rdy;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;

    // The first three bytes of a word wait in 'shift'; the fourth byte is
    // concatenated straight into wdata so the write is issued on the very
    // edge that accepts it, with no extra pipeline stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            n_words   <= '0;
            word_idx  <= '0;
            acc       <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_HDR;
                        byte_cnt  <= '0;
                        word_idx  <= '0;
                        acc       <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        if (bus.in_data != 8'd0 && {1'b0, bus.in_data} <= MAX_N) begin
                            n_words <= bus.in_data;
                            state   <= S_DATA;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        acc      <= acc ^ bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            we_q     <= 1'b1;
                            waddr_q  <= word_idx[AW-1:0];
                            wdata_q  <= {shift, bus.in_data};
                            word_idx <= word_idx + 8'd1;
                            if (word_idx == n_words - 8'd1) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            shift <= {shift[15:0], bus.in_data};
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (bus.in_data == acc) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. Frames are built with random data,
//   driven with optional random bubbles, and the observed memory writes and
//   status outputs are compared against a frame-level reference model.
module tb_imem_loader;

    localparam int WORDS = 16;
    localparam int AW    = 4;

    typedef logic [7:0] byte_q_t[$];

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic error;
    logic cpu_rst_n;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(
        .WORDS(WORDS),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] act_w[$];
    logic [35:0] exp_w[$];
    logic        exp_ok;
    logic        we_at_last;
    logic        cpu_at_last;
    int          stall_cycles;

    // Every cycle with the strobe high is one recorded write.
    always @(negedge clk) begin
        if (bus.we === 1'b1) act_w.push_back({bus.waddr, bus.wdata});
    end

    // Reference model: what a frame should write and whether it should pass.
    task automatic model_frame(input byte_q_t f);
        int n;
        logic [7:0] x;
        exp_w.delete();
        exp_ok = 1'b0;
        n = int'(f[0]);
        if (n < 1 || n > WORDS) return;
        for (int k = 0; k < n; k++)
            exp_w.push_back({AW'(k), f[1+4*k], f[2+4*k], f[3+4*k], f[4+4*k]});
        x = 8'h00;
        for (int i = 1; i <= 4 * n; i++) x = x ^ f[i];
        exp_ok = (f[4*n+1] == x);
    endtask

    task automatic make_frame(input int n, input bit good, output byte_q_t f);
        logic [7:0] b;
        logic [7:0] x;
        f = {};
        f.push_back(8'(n));
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            x = x ^ b;
        end
        f.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives bytes at negedges; start_at >= 0 raises start alongside that byte.
    task automatic send_frame(input byte_q_t f, input int gap_pct, input int start_at);
        int waited;
        stall_cycles = 0;
        for (int i = 0; i < f.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            if (i == start_at) start = 1'b1;
            if (i == f.size() - 1) begin
                we_at_last  = bus.we;
                cpu_at_last = cpu_rst_n;
            end
            waited = 0;
            while (bus.in_ready !== 1'b1 && waited < 32) begin
                @(negedge clk);
                waited++;
                stall_cycles++;
            end
            if (bus.in_ready !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL byte_accept_timeout: byte %0d never accepted, in_ready=%b required 1", i, bus.in_ready);
                bus.in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(negedge clk);
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b expected 0", bus.we); end
        n_checks++; if (bus.waddr !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_waddr: got %h expected 0", bus.waddr); end
        n_checks++; if (bus.wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wdata: got %h expected 0", bus.wdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_in_ready: got %b expected 0", bus.in_ready); end
    endtask

    task automatic test_single_word();
        byte_q_t f;
        f = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        act_w.delete();
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_hdr: got %b expected 1", busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_ready_hdr: got %b expected 1", bus.in_ready); end
        send_frame(f, 0, -1);
        n_checks++; if (act_w.size() != 1) begin n_fail++; $display("[TB] FAIL single_write_count: got %0d expected 1", act_w.size()); end
        n_checks++; if (act_w.size() < 1 || act_w[0] !== 36'h0_12345678) begin n_fail++; $display("[TB] FAIL single_write: got %h expected 012345678", (act_w.size() > 0) ? act_w[0] : 36'hX); end
        n_checks++; if (we_at_last !== 1'b1) begin n_fail++; $display("[TB] FAIL single_we_during_csum: got %b expected 1", we_at_last); end
        n_checks++; if (cpu_at_last !== 1'b0) begin n_fail++; $display("[TB] FAIL single_cpu_during_csum: got %b expected 0", cpu_at_last); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL single_done: got %b expected 1", done); end
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("[TB] FAIL single_cpu_rst_n: got %b expected 1", cpu_rst_n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_done: got %b expected 0", busy); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ready_done: got %b expected 0", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        byte_q_t f;
        logic [31:0] w;
        logic [7:0]  x;
        f = {};
        f.push_back(8'd16);
        x = 8'h00;
        for (int k = 0; k < 16; k++) begin
            w = 32'h01010101 * 32'(k);
            for (int j = 3; j >= 0; j--) begin
                f.push_back(w[8*j +: 8]);
                x = x ^ w[8*j +: 8];
            end
        end
        f.push_back(x);
        model_frame(f);
        act_w.delete();
        pulse_start();
        send_frame(f, 0, -1);
        n_checks++; if (stall_cycles != 0) begin n_fail++; $display("[TB] FAIL b2b_stalls: got %0d expected 0", stall_cycles); end
        n_checks++; if (act_w.size() != exp_w.size()) begin n_fail++; $display("[TB] FAIL b2b_write_count: got %0d expected %0d", act_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            n_checks++;
            if (i >= act_w.size() || act_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("[TB] FAIL b2b_write_%0d: got %h expected %h", i, (i < act_w.size()) ? act_w[i] : 36'hX, exp_w[i]);
            end
        end
        n_checks++; if (we_at_last !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_we_during_csum: got %b expected 1", we_at_last); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done: got %b expected 1", done); end
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_cpu_rst_n: got %b expected 1", cpu_rst_n); end
    endtask

    task automatic test_gaps_bad_checksum();
        byte_q_t f;
        make_frame(2, 1'b0, f);
        model_frame(f);
        act_w.delete();
        pulse_start();
        send_frame(f, 40, -1);
        n_checks++; if (act_w.size() != 2) begin n_fail++; $display("[TB] FAIL badcsum_write_count: got %0d expected 2", act_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            n_checks++;
            if (i >= act_w.size() || act_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("[TB] FAIL badcsum_write_%0d: got %h expected %h", i, (i < act_w.size()) ? act_w[i] : 36'hX, exp_w[i]);
            end
        end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("[TB] FAIL badcsum_error: got %b expected 1", error); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL badcsum_done: got %b expected 0", done); end
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL badcsum_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL badcsum_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL badcsum_busy: got %b expected 0", busy); end
    endtask

    task automatic test_bad_header();
        byte_q_t f;
        logic [7:0] hdrs[2];
        hdrs[0] = 8'h00;
        hdrs[1] = 8'h11;
        for (int h = 0; h < 2; h++) begin
            f = {};
            f.push_back(hdrs[h]);
            act_w.delete();
            pulse_start();
            send_frame(f, 0, -1);
            repeat (2) @(negedge clk);
            n_checks++; if (error !== 1'b1) begin n_fail++; $display("[TB] FAIL badhdr_%h_error: got %b expected 1", hdrs[h], error); end
            n_checks++; if (act_w.size() != 0) begin n_fail++; $display("[TB] FAIL badhdr_%h_writes: got %0d expected 0", hdrs[h], act_w.size()); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL badhdr_%h_in_ready: got %b expected 0", hdrs[h], bus.in_ready); end
            n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL badhdr_%h_cpu_rst_n: got %b expected 0", hdrs[h], cpu_rst_n); end
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t f;
        byte_q_t part;
        logic [35:0] word0;
        make_frame(3, 1'b1, f);
        model_frame(f);
        word0 = exp_w[0];
        part = f[0:6];
        act_w.delete();
        pulse_start();
        send_frame(part, 0, -1);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (bus.waddr !== 4'h0 || bus.wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_wbus: got %h/%h expected 0/0", bus.waddr, bus.wdata); end
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (act_w.size() != 1) begin n_fail++; $display("[TB] FAIL midrst_write_count: got %0d expected 1", act_w.size()); end
        n_checks++; if (act_w.size() < 1 || act_w[0] !== word0) begin n_fail++; $display("[TB] FAIL midrst_word0: got %h expected %h", (act_w.size() > 0) ? act_w[0] : 36'hX, word0); end
        make_frame($urandom_range(16, 1), 1'b1, f);
        model_frame(f);
        act_w.delete();
        pulse_start();
        send_frame(f, 25, -1);
        n_checks++; if (act_w.size() != exp_w.size()) begin n_fail++; $display("[TB] FAIL midrst_fresh_count: got %0d expected %0d", act_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            n_checks++;
            if (i >= act_w.size() || act_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("[TB] FAIL midrst_fresh_write_%0d: got %h expected %h", i, (i < act_w.size()) ? act_w[i] : 36'hX, exp_w[i]);
            end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_fresh_done: got %b expected 1", done); end
    endtask

    task automatic test_start_handling();
        byte_q_t f;
        make_frame(4, 1'b1, f);
        model_frame(f);
        act_w.delete();
        pulse_start();
        send_frame(f, 20, 6);
        n_checks++; if (act_w.size() != exp_w.size()) begin n_fail++; $display("[TB] FAIL start_data_count: got %0d expected %0d", act_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            n_checks++;
            if (i >= act_w.size() || act_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("[TB] FAIL start_data_write_%0d: got %h expected %h", i, (i < act_w.size()) ? act_w[i] : 36'hX, exp_w[i]);
            end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL start_data_done: got %b expected 1", done); end
        start = 1'b1;
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("[TB] FAIL start_done_before_edge: got %b expected 1", cpu_rst_n); end
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL start_done_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL start_done_done: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL start_done_busy: got %b expected 1", busy); end
        make_frame(1, 1'b1, f);
        act_w.delete();
        send_frame(f, 0, -1);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL start_reload_done: got %b expected 1", done); end
    endtask

    task automatic test_random_frames();
        byte_q_t f;
        for (int it = 0; it < 6; it++) begin
            make_frame($urandom_range(16, 1), 1'($urandom_range(1, 0)), f);
            model_frame(f);
            act_w.delete();
            pulse_start();
            send_frame(f, 30, -1);
            n_checks++; if (act_w.size() != exp_w.size()) begin n_fail++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, act_w.size(), exp_w.size()); end
            for (int i = 0; i < exp_w.size(); i++) begin
                n_checks++;
                if (i >= act_w.size() || act_w[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("[TB] FAIL rand%0d_write_%0d: got %h expected %h", it, i, (i < act_w.size()) ? act_w[i] : 36'hX, exp_w[i]);
                end
            end
            n_checks++; if (done !== exp_ok) begin n_fail++; $display("[TB] FAIL rand%0d_done: got %b expected %b", it, done, exp_ok); end
            n_checks++; if (error !== !exp_ok) begin n_fail++; $display("[TB] FAIL rand%0d_error: got %b expected %b", it, error, !exp_ok); end
            n_checks++; if (cpu_rst_n !== exp_ok) begin n_fail++; $display("[TB] FAIL rand%0d_cpu_rst_n: got %b expected %b", it, cpu_rst_n, exp_ok); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        $display("[TB] starting imem_loader bench");
        test_reset();
        test_single_word();
        test_back_to_back();
        test_gaps_bad_checksum();
        test_bad_header();
        test_reset_mid_frame();
        test_start_handling();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
